seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//   Time-multiplexed N-digit 7-segment display driver. Latches a packed hex value
//   plus per-digit decimal points, scans one digit at a time through a shared
//   active-low segment bus, and supports anti-ghost blanking and leading-zero
//   blanking. Sits between the counter/datapath logic and board LED pins.
// PARAMETERS
//   NUM_DIGITS    4     digits scanned, legal range 1..8
//   SCAN_DIV      1000  clock cycles per digit slot, >= 2
//   BLANK_CYCLES  2     cycles at start of each slot with all digits off, < SCAN_DIV
// PORTS
//   clk         in   1             system clock, rising edge
//   rst_n       in   1             asynchronous active-low reset
//   enable      in   1             scan enable; low = display dark, scan restarts
//   load        in   1             one-cycle strobe: capture value/dp_in/blank_lz
//   value       in   4*NUM_DIGITS  packed hex; nibble k = digit k (digit 0 = LSD)
//   dp_in       in   NUM_DIGITS    decimal point per digit, 1 = lit
//   blank_lz    in   1             1 = blank leading zeros
//   seg_out     out  8             active-low segments: [7:1]=a..g, [0]=dp
//   dig_sel_n   out  NUM_DIGITS    active-low one-hot digit enable
//   frame_done  out  1             one-cycle pulse when scan wraps to digit 0
// BEHAVIOUR
//   Reset (async, rst_n=0): seg_out=8'hFF, dig_sel_n all 1, frame_done=0,
//     prescaler=0, index=0, display and pending regs = 0, pending_valid=0.
//   Prescaler presc counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and
//     index advances, NUM_DIGITS-1 wraps to 0. Wrap cycle: frame_done=1 (registered).
//   Double buffer: load writes pending regs and sets pending_valid. Multiple
//     loads in one frame: last wins. On the frame-wrap cycle, pending is copied to
//     display and pending_valid clears. load on the wrap cycle bypasses pending.
//     Its data is committed directly, so no frame ever shows a mixed value.
//   Output stage, registered, 1-cycle latency from presc/index:
//     presc < BLANK_CYCLES: dig_sel_n all 1, seg_out=8'hFF.
//     Otherwise: dig_sel_n bit[index]=0, others 1, seg_out=decode(display nibble).
//   Decode, dp bit=1: 0:03 1:9F 2:25 3:0D 4:99 5:49 6:41 7:1F
//     8:01 9:09 A:11 B:C1 C:E5 D:85 E:61 F:71. dp lit clears bit0.
//   Leading-zero blank (display copy of blank_lz=1): digit k is blanked if nibbles
//     k..NUM_DIGITS-1 are all 0 and k != 0. Blanked digit: seg[7:1]=7'h7F, dp still
//     driven, dig_sel_n still asserted. Digit 0 is never blanked.
//   enable=0: presc=0, index=0, frame_done=0, outputs dark next cycle.
//     Load/commit still work; commit happens at once while disabled.
//     On re-enable, scan starts at digit 0 with a blank window.
//   Reset mid-scan: outputs dark immediately; pending load is lost.
//   Frame period = NUM_DIGITS*SCAN_DIV cycles. Exactly one digit is active at a time.
// TESTING  (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2)
//   Assert rst_n=0 mid-scan -> seg_out=FF, dig_sel_n=4'hF that cycle; frame_done=0.
//   load 16'h12AF, dp=0, blank_lz=0 -> next frame: digit0=71, digit1=11, digit2=25,
//     digit3=9F. dig_sel_n E,D,B,7, each active 6 cycles after 2 dark; frame_done every 32.
//   load 16'h0050, blank_lz=1 -> digits3,2 seg=FF with select asserted; digit1=49,
//     digit0=03. load 16'h0000 -> only digit0 shows 03.
//   load 16'h0005, dp_in=4'b0100, blank_lz=1 -> digit2 seg=FE, digit0=49, digit3=FF.
//   load 16'h1111 at cycle 10 of frame -> frame still shows old value until wrap.
//     load on the wrap cycle -> new value shown in the frame that starts then.
//   enable low for 5 cycles at index 2 -> dark, frame_done silent. Re-enable ->
//     digit0 selected after 2 blank cycles.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: double-buffered hex value, per-digit
// decimal points, anti-ghost blank window and optional leading-zero blanking.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel_n,
  output logic                    frame_done
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  // Segment patterns are active-low with the dp bit (bit 0) left dark.
  function automatic logic [7:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 8'h03;  4'h1: decode = 8'h9F;
      4'h2: decode = 8'h25;  4'h3: decode = 8'h0D;
      4'h4: decode = 8'h99;  4'h5: decode = 8'h49;
      4'h6: decode = 8'h41;  4'h7: decode = 8'h1F;
      4'h8: decode = 8'h01;  4'h9: decode = 8'h09;
      4'hA: decode = 8'h11;  4'hB: decode = 8'hC1;
      4'hC: decode = 8'hE5;  4'hD: decode = 8'h85;
      4'hE: decode = 8'h61;  default: decode = 8'h71;
    endcase
  endfunction

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  fd_q, fd_d;
  logic [VW-1:0]         disp_val_q, disp_val_d, pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic                  disp_lz_q, disp_lz_d, pend_lz_q, pend_lz_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;

  logic term, last, wrap, commit;

  always_comb begin
    term   = (presc_q == PW'(SCAN_DIV - 1));
    last   = (idx_q == IW'(NUM_DIGITS - 1));
    wrap   = enable && term && last;
    // While disabled the display is not being scanned, so commits are immediate.
    commit = wrap || !enable;

    presc_d = presc_q;
    idx_d   = idx_q;
    fd_d    = 1'b0;
    if (!enable) begin
      presc_d = '0;
      idx_d   = '0;
    end else if (term) begin
      presc_d = '0;
      idx_d   = last ? '0 : idx_q + IW'(1);
      fd_d    = wrap;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    disp_lz_d    = disp_lz_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_lz_d    = pend_lz_q;
    pend_valid_d = pend_valid_q;
    if (commit) begin
      pend_valid_d = 1'b0;
      if (load) begin
        disp_val_d = value;
        disp_dp_d  = dp_in;
        disp_lz_d  = blank_lz;
      end else if (pend_valid_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
        disp_lz_d  = pend_lz_q;
      end
    end else if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp_in;
      pend_lz_d    = blank_lz;
      pend_valid_d = 1'b1;
    end
  end

  logic [NUM_DIGITS:0] zero_above;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;

  always_comb begin
    // zero_above[k]: nibbles k..NUM_DIGITS-1 of the display value are all zero.
    zero_above[NUM_DIGITS] = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--)
      zero_above[k] = zero_above[k+1] && (disp_val_q[4*k +: 4] == 4'h0);

    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    sel_d     = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_nib   = disp_val_q[4*k +: 4];
        cur_dp    = disp_dp_q[k];
        cur_blank = disp_lz_q && zero_above[k] && (k != 0);
        sel_d[k]  = 1'b0;
      end
    end

    seg_d = decode(cur_nib);
    if (cur_blank) seg_d[7:1] = 7'h7F;
    if (cur_dp)    seg_d[0]   = 1'b0;

    if (!enable || (int'(presc_q) < BLANK_CYCLES)) begin
      seg_d = 8'hFF;
      sel_d = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      fd_q         <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_lz_q    <= 1'b0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_lz_q    <= 1'b0;
      pend_valid_q <= 1'b0;
      seg_q        <= 8'hFF;
      sel_q        <= '1;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      fd_q         <= fd_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      disp_lz_q    <= disp_lz_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_lz_q    <= pend_lz_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
    end
  end

  assign seg_out    = seg_q;
  assign dig_sel_n  = sel_q;
  assign frame_done = fd_q;
endmodule
